// File: rtl/fetch_sequencer.sv
// Byte-stream instruction fetch sequencer: reads opcode (+ optional immediate) bytes from memory
// and presents them to the decoder, with redirect, halt/resume and read-discard handling.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [7:0] HLT_OPCODE = 8'hFF
) (
  input  logic       internal_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       resume,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic [7:0] instr_pc,
  output logic       halted
);

  typedef enum logic [2:0] {StIdle, StFetchOp, StFetchImm, StIssue, StHalt} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       discard_q, discard_d;
  logic       mem_req_q, mem_req_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic       valid_q, valid_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] ipc_q, ipc_d;
  logic       halted_q, halted_d;
  logic [7:0] redirect_pc;

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 8'h00;
      valid_q    <= 1'b0;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      ipc_q      <= 8'h00;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      ipc_q      <= ipc_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    ipc_d       = ipc_q;
    halted_d    = halted_q;
    redirect_pc = jump_en ? jump_addr : pc_q;

    case (state_q)
      StIdle: begin
        pc_d = redirect_pc;
        if (enable) begin
          state_d    = StFetchOp;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc;
        end
      end

      StFetchOp, StFetchImm: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            if (discard_q || jump_en) begin
              // Redirected read: drop the byte and restart at the new pc after the gap cycle
              discard_d = 1'b0;
              pc_d      = redirect_pc;
              state_d   = StFetchOp;
            end else begin
              pc_d = pc_q + 8'd1;
              if (state_q == StFetchOp) begin
                opcode_d  = mem_data;
                ipc_d     = pc_q;
                operand_d = 8'h00;
                if (mem_data == HLT_OPCODE) begin
                  state_d  = StHalt;
                  halted_d = 1'b1;
                end else if (mem_data[7:6] == 2'b11) begin
                  state_d = StFetchImm;
                end else begin
                  state_d = StIssue;
                  valid_d = 1'b1;
                end
              end else begin
                operand_d = mem_data;
                state_d   = StIssue;
                valid_d   = 1'b1;
              end
            end
          end else if (jump_en) begin
            discard_d = 1'b1;
            pc_d      = jump_addr;
            state_d   = StFetchOp;
          end
        end else if (jump_en && !enable) begin
          pc_d    = jump_addr;
          state_d = StIdle;
        end else begin
          // Gap cycle after an ack: raise the next request
          pc_d       = redirect_pc;
          state_d    = jump_en ? StFetchOp : state_q;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc;
        end
      end

      StIssue: begin
        if (instr_ready || jump_en) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          if (enable) begin
            state_d    = StFetchOp;
            mem_req_d  = 1'b1;
            mem_addr_d = redirect_pc;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StHalt: begin
        if (resume) begin
          halted_d   = 1'b0;
          state_d    = StFetchOp;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized programs checked against a
// program-walking reference model.
module tb_fetch_sequencer;

  logic       internal_clock = 1'b0;
  logic       reset, enable, resume, jump_en;
  logic [7:0] jump_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       instr_valid, instr_ready;
  logic [7:0] instr_opcode, instr_operand, instr_pc;
  logic       halted;

  always #5 internal_clock = ~internal_clock;

  fetch_sequencer #(
    .RESET_PC  (8'h00),
    .HLT_OPCODE(8'hFF)
  ) dut (
    .internal_clock(internal_clock),
    .reset         (reset),
    .enable        (enable),
    .resume        (resume),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_pc      (instr_pc),
    .halted        (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [256];
  int          ack_delay, wait_cnt;
  bit          rand_delay, rand_ready, force_ack, junk_ack, ready_val;
  logic [23:0] issued[$];
  logic [7:0]  ack_addrs[$];
  logic [23:0] exp_q[$];
  logic [7:0]  exp_halt_pc;

  bit          p_req, p_ack, p_valid, p_hs, p_jump, p_reset;
  logic [7:0]  p_addr, p_op, p_opd, p_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory responder and decoder drive this cycle, then protocol checks after the edge.
  task automatic step();
    bit hs;
    mem_ack  = 1'b0;
    mem_data = 8'($urandom);
    if (force_ack) begin
      mem_ack  = 1'b1;
      mem_data = 8'h55;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        if (!reset) ack_addrs.push_back(mem_addr);
        wait_cnt = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
      end else begin
        wait_cnt--;
      end
    end else if (junk_ack) begin
      mem_ack = ($urandom_range(0, 3) == 0);
    end
    instr_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_val;
    hs = instr_valid && instr_ready && !reset;
    if (hs) issued.push_back({instr_opcode, instr_operand, instr_pc});
    p_req = mem_req;  p_ack = mem_ack;  p_addr = mem_addr;  p_valid = instr_valid;
    p_hs = hs;  p_jump = jump_en;  p_reset = reset;
    p_op = instr_opcode;  p_opd = instr_operand;  p_pc = instr_pc;
    @(posedge internal_clock);
    #1;
    if (!p_reset && p_req && p_ack) check("req_drop_after_ack", 32'(mem_req), 32'd0);
    if (!p_reset && p_req && !p_ack) begin
      check("req_held", 32'(mem_req), 32'd1);
      check("addr_held", 32'(mem_addr), 32'(p_addr));
    end
    if (!p_reset && p_valid && !p_hs && !p_jump) begin
      check("valid_held", 32'(instr_valid), 32'd1);
      check("fields_held", {8'h00, instr_opcode, instr_operand, instr_pc}, {8'h00, p_op, p_opd, p_pc});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;  enable = 1'b0;  resume = 1'b0;  jump_en = 1'b0;  jump_addr = 8'h00;
    force_ack = 1'b0;  junk_ack = 1'b0;  rand_delay = 1'b0;  rand_ready = 1'b0;
    ready_val = 1'b1;  ack_delay = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    step();
    step();
    reset = 1'b0;
    wait_cnt = 0;
    issued.delete();
    ack_addrs.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_fields"}, {8'h00, instr_opcode, instr_operand, instr_pc}, 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  task automatic run_until_issue(input int n, input int budget, input string tag);
    for (int c = 0; c < budget && issued.size() < n; c++) step();
    check(tag, issued.size(), n);
  endtask

  task automatic run_until_halt(input int budget, input string tag);
    for (int c = 0; c < budget && halted !== 1'b1; c++) step();
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic jump_idle(input logic [7:0] target);
    enable = 1'b0;  jump_en = 1'b1;  jump_addr = target;
    step();
    jump_en = 1'b0;
  endtask

  // Walk the program as the decoder should see it: opcode, optional immediate, stop at HLT.
  task automatic model(input logic [7:0] start);
    logic [7:0] pc, op, opd, ipc;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      op = mem[pc];  ipc = pc;  pc = pc + 8'd1;
      if (op == 8'hFF) break;
      if (op[7:6] == 2'b11) begin
        opd = mem[pc];  pc = pc + 8'd1;
      end else begin
        opd = 8'h00;
      end
      exp_q.push_back({op, opd, ipc});
    end
    exp_halt_pc = pc;
  endtask

  initial begin
    logic [7:0] start, hpos, b;
    instr_ready = 1'b0;  mem_ack = 1'b0;  mem_data = 8'h00;
    do_reset();
    check_reset_outputs("reset_state");

    // Short program with an immediate and HLT; HLT must not reach the decoder
    do_reset();
    mem[0] = 8'h12;  mem[1] = 8'hC4;  mem[2] = 8'h56;  mem[3] = 8'hFF;
    enable = 1'b1;
    run_until_halt(40, "prog_halts");
    check("prog_issue_count", issued.size(), 2);
    if (issued.size() >= 2) begin
      check("prog_issue0", 32'(issued[0]), 32'({8'h12, 8'h00, 8'h00}));
      check("prog_issue1", 32'(issued[1]), 32'({8'hC4, 8'h56, 8'h01}));
    end
    check("halt_no_req", 32'(mem_req), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_unhalt", 32'(halted), 32'd0);
    check("resume_req", 32'(mem_req), 32'd1);
    check("resume_addr", 32'(mem_addr), 32'h04);

    // Decoder back-pressure
    do_reset();
    mem[0] = 8'h12;  mem[1] = 8'h34;
    ready_val = 1'b0;  enable = 1'b1;
    for (int c = 0; c < 20 && instr_valid !== 1'b1; c++) step();
    check("stall_valid", 32'(instr_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_valid_held", 32'(instr_valid), 32'd1);
      check("stall_fields", {8'h00, instr_opcode, instr_operand, instr_pc}, 32'h00120000);
      check("stall_no_req", 32'(mem_req), 32'd0);
    end
    ready_val = 1'b1;
    step();
    check("stall_release_valid", 32'(instr_valid), 32'd0);
    check("stall_release_req", 32'(mem_req), 32'd1);
    check("stall_release_addr", 32'(mem_addr), 32'h01);
    check("stall_issue_count", issued.size(), 1);

    // Redirect while a slow read is outstanding
    do_reset();
    mem[8'h05] = 8'h22;  mem[8'h80] = 8'h33;
    ack_delay = 3;  wait_cnt = 3;
    jump_idle(8'h05);
    check("jump_idle_stays", 32'(mem_req), 32'd0);
    enable = 1'b1;
    step();
    check("pend_req", 32'(mem_req), 32'd1);
    check("pend_addr", 32'(mem_addr), 32'h05);
    jump_en = 1'b1;  jump_addr = 8'h80;
    step();
    jump_en = 1'b0;
    run_until_issue(1, 40, "discard_issue");
    if (issued.size() >= 1) check("discard_issue0", 32'(issued[0]), 32'({8'h33, 8'h00, 8'h80}));
    check("discard_ack_count", ack_addrs.size(), 2);
    if (ack_addrs.size() >= 2) check("discard_next_addr", 32'(ack_addrs[1]), 32'h80);

    // pc wrap during an immediate read
    do_reset();
    mem[8'hFF] = 8'hC0;  mem[8'h00] = 8'h9A;  mem[8'h01] = 8'h11;
    jump_idle(8'hFF);
    enable = 1'b1;
    run_until_issue(2, 40, "wrap_issues");
    if (issued.size() >= 2) begin
      check("wrap_issue0", 32'(issued[0]), 32'({8'hC0, 8'h9A, 8'hFF}));
      check("wrap_issue1", 32'(issued[1]), 32'({8'h11, 8'h00, 8'h01}));
    end
    if (ack_addrs.size() >= 3) begin
      check("wrap_imm_addr", 32'(ack_addrs[1]), 32'h00);
      check("wrap_next_addr", 32'(ack_addrs[2]), 32'h01);
    end

    // Reset during an immediate read, with a late ack afterwards
    do_reset();
    mem[0] = 8'hC5;  mem[1] = 8'h77;
    ack_delay = 1;  wait_cnt = 1;  enable = 1'b1;
    for (int c = 0; c < 20 && !(mem_req === 1'b1 && mem_addr === 8'h01); c++) step();
    check("imm_read_seen", {31'd0, mem_req === 1'b1 && mem_addr === 8'h01}, 32'd1);
    reset = 1'b1;
    step();
    check_reset_outputs("midread_reset");
    reset = 1'b0;  enable = 1'b0;  force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check_reset_outputs("late_ack");
    for (int c = 0; c < 3; c++) begin
      step();
      check("late_ack_no_valid", 32'(instr_valid), 32'd0);
    end

    // Jump ignored in HALT; resume beats jump
    do_reset();
    mem[0] = 8'hFF;
    enable = 1'b1;
    run_until_halt(20, "hlt_first");
    check("hlt_not_issued", issued.size(), 0);
    jump_en = 1'b1;  jump_addr = 8'h40;
    step();
    check("halt_jump_ignored", 32'(halted), 32'd1);
    check("halt_jump_no_req", 32'(mem_req), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;  jump_en = 1'b0;
    check("resume_wins_halted", 32'(halted), 32'd0);
    check("resume_wins_addr", 32'(mem_addr), 32'h01);

    // Randomized programs, delays, back-pressure, enable and stray acks
    for (int r = 0; r < 4; r++) begin
      do_reset();
      start = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        mem[i] = (b == 8'hFF) ? 8'h3F : b;
      end
      hpos = start + 8'($urandom_range(8, 60));
      mem[hpos] = 8'hFF;
      mem[8'(hpos + 8'd1)] = 8'hFF;
      model(start);
      jump_idle(start);
      rand_delay = 1'b1;  rand_ready = 1'b1;  junk_ack = 1'b1;  wait_cnt = 0;
      for (int c = 0; c < 4000 && halted !== 1'b1; c++) begin
        enable = ($urandom_range(0, 4) != 0);
        step();
      end
      check("rand_halted", 32'(halted), 32'd1);
      check("rand_issue_count", issued.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
        check("rand_issue", 32'(issued[i]), 32'(exp_q[i]));
      enable = 1'b1;  resume = 1'b1;
      step();
      resume = 1'b0;
      check("rand_resume_addr", 32'(mem_addr), 32'(exp_halt_pc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
